alu_issue_arbiter: RTL and testbench

ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

---
 rtl/alu_issue_arbiter.sv | 109 ++++++++++
 tb/tb_alu_issue_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: dual-issue arbiter steering an instruction pair onto a branch-capable ALU A
// and an arithmetic-only ALU B, splitting dependent or double-branch pairs over two cycles.
module alu_issue_arbiter #(
    parameter int          RW         = 5,
    parameter logic [15:0] SPLIT_INIT = 16'h0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    input  logic          req1_valid,
    input  logic [3:0]    req0_op,
    input  logic [3:0]    req1_op,
    input  logic          req0_br,
    input  logic          req1_br,
    input  logic [RW-1:0] req0_rd,
    input  logic [RW-1:0] req0_rs1,
    input  logic [RW-1:0] req0_rs2,
    input  logic [RW-1:0] req1_rd,
    input  logic [RW-1:0] req1_rs1,
    input  logic [RW-1:0] req1_rs2,
    output logic          req_ready,
    input  logic          stall,
    input  logic          flush,
    output logic          alu_a_valid,
    output logic [3:0]    alu_a_op,
    output logic          alu_a_slot,
    output logic          alu_b_valid,
    output logic [3:0]    alu_b_op,
    output logic          alu_b_slot,
    output logic [15:0]   split_count
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state;
    logic [3:0] held_op;
    logic       both;
    logic       rd0_live;
    logic       conflict;

    assign req_ready = (state == IDLE) & ~stall;
    assign both      = req0_valid & req1_valid;
    assign rd0_live  = req0_rd != '0;
    // RAW hazard, double branch, or WAW against a branch in the younger slot all force a split
    assign conflict  = both & ((req0_br & req1_br) |
                               (rd0_live & (req0_rd == req1_rs1 | req0_rd == req1_rs2)) |
                               (req1_br & rd0_live & req0_rd == req1_rd));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            held_op     <= '0;
            alu_a_valid <= 1'b0;
            alu_a_op    <= '0;
            alu_a_slot  <= 1'b0;
            alu_b_valid <= 1'b0;
            alu_b_op    <= '0;
            alu_b_slot  <= 1'b0;
            split_count <= SPLIT_INIT;
        end else if (flush) begin
            state       <= IDLE;
            held_op     <= '0;
            alu_a_valid <= 1'b0;
            alu_a_op    <= '0;
            alu_a_slot  <= 1'b0;
            alu_b_valid <= 1'b0;
            alu_b_op    <= '0;
            alu_b_slot  <= 1'b0;
        end else if (!stall) begin
            alu_a_valid <= 1'b0;
            alu_a_op    <= '0;
            alu_a_slot  <= 1'b0;
            alu_b_valid <= 1'b0;
            alu_b_op    <= '0;
            alu_b_slot  <= 1'b0;
            if (state == HOLD) begin
                alu_a_valid <= 1'b1;
                alu_a_op    <= held_op;
                alu_a_slot  <= 1'b1;
                held_op     <= '0;
                state       <= IDLE;
            end else if (conflict) begin
                alu_a_valid <= 1'b1;
                alu_a_op    <= req0_op;
                held_op     <= req1_op;
                state       <= HOLD;
                split_count <= (split_count == 16'hFFFF) ? split_count : split_count + 16'd1;
            end else if (both && req1_br && !req0_br) begin
                alu_a_valid <= 1'b1;
                alu_a_op    <= req1_op;
                alu_a_slot  <= 1'b1;
                alu_b_valid <= 1'b1;
                alu_b_op    <= req0_op;
            end else if (both) begin
                alu_a_valid <= 1'b1;
                alu_a_op    <= req0_op;
                alu_b_valid <= 1'b1;
                alu_b_op    <= req1_op;
                alu_b_slot  <= 1'b1;
            end else if (req0_valid) begin
                alu_a_valid <= 1'b1;
                alu_a_op    <= req0_op;
            end else if (req1_valid) begin
                alu_a_valid <= 1'b1;
                alu_a_op    <= req1_op;
                alu_a_slot  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: scoreboard bench; a queue-based issue model predicts each cycle's ALU outputs,
// a second instance preloaded near saturation exercises the split counter ceiling.
module tb_alu_issue_arbiter;
    typedef struct packed {
        logic       v;
        logic [3:0] op;
        logic       br;
        logic [4:0] rd, rs1, rs2;
    } ins_t;
    typedef struct packed {
        logic       av;
        logic [3:0] aop;
        logic       as;
        logic       bv;
        logic [3:0] bop;
        logic       bs;
        logic [15:0] cnt, cnt2;
    } exp_t;

    logic clk = 0, reset = 1, stall = 0, flush = 0;
    ins_t r0 = '0, r1 = '0;
    logic req_ready, req_ready2;
    logic av, as, bv, bs, av2, as2, bv2, bs2;
    logic [3:0] aop, bop, aop2, bop2;
    logic [15:0] cnt, cnt2;

    int checks = 0, errors = 0;
    exp_t exp_q[$];
    ins_t held_q[$];
    exp_t cur;

    always #5 clk = ~clk;

    alu_issue_arbiter #(.RW(5)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(r0.v), .req1_valid(r1.v), .req0_op(r0.op), .req1_op(r1.op),
        .req0_br(r0.br), .req1_br(r1.br),
        .req0_rd(r0.rd), .req0_rs1(r0.rs1), .req0_rs2(r0.rs2),
        .req1_rd(r1.rd), .req1_rs1(r1.rs1), .req1_rs2(r1.rs2),
        .req_ready(req_ready), .stall(stall), .flush(flush),
        .alu_a_valid(av), .alu_a_op(aop), .alu_a_slot(as),
        .alu_b_valid(bv), .alu_b_op(bop), .alu_b_slot(bs),
        .split_count(cnt)
    );

    alu_issue_arbiter #(.RW(5), .SPLIT_INIT(16'hFFFE)) dut_sat (
        .clk(clk), .reset(reset),
        .req0_valid(r0.v), .req1_valid(r1.v), .req0_op(r0.op), .req1_op(r1.op),
        .req0_br(r0.br), .req1_br(r1.br),
        .req0_rd(r0.rd), .req0_rs1(r0.rs1), .req0_rs2(r0.rs2),
        .req1_rd(r1.rd), .req1_rs1(r1.rs1), .req1_rs2(r1.rs2),
        .req_ready(req_ready2), .stall(stall), .flush(flush),
        .alu_a_valid(av2), .alu_a_op(aop2), .alu_a_slot(as2),
        .alu_b_valid(bv2), .alu_b_op(bop2), .alu_b_slot(bs2),
        .split_count(cnt2)
    );

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic ins_t mk(input bit v, input logic [3:0] op, input bit br,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        mk = '{v: v, op: op, br: br, rd: rd, rs1: rs1, rs2: rs2};
    endfunction

    function automatic exp_t reset_state();
        reset_state = '0;
        reset_state.cnt2 = 16'hFFFE;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        sat_inc = (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Model: an instruction waiting for its second cycle sits in held_q; outputs follow the steering rules.
    task automatic model_step(input ins_t i0, input ins_t i1, input bit st, input bit fl);
        exp_t n;
        bit conf;
        n = cur;
        if (fl) begin
            n.av = 0; n.aop = 0; n.as = 0; n.bv = 0; n.bop = 0; n.bs = 0;
            held_q.delete();
        end else if (!st) begin
            n.av = 0; n.aop = 0; n.as = 0; n.bv = 0; n.bop = 0; n.bs = 0;
            if (held_q.size() != 0) begin
                n.av = 1; n.aop = held_q[0].op; n.as = 1;
                held_q.delete();
            end else if (i0.v && i1.v) begin
                conf = (i0.br && i1.br) ||
                       (i0.rd != 0 && (i0.rd == i1.rs1 || i0.rd == i1.rs2)) ||
                       (i1.br && i0.rd != 0 && i0.rd == i1.rd);
                if (conf) begin
                    n.av = 1; n.aop = i0.op;
                    held_q.push_back(i1);
                    n.cnt = sat_inc(n.cnt);
                    n.cnt2 = sat_inc(n.cnt2);
                end else if (i1.br && !i0.br) begin
                    n.av = 1; n.aop = i1.op; n.as = 1;
                    n.bv = 1; n.bop = i0.op;
                end else begin
                    n.av = 1; n.aop = i0.op;
                    n.bv = 1; n.bop = i1.op; n.bs = 1;
                end
            end else if (i0.v) begin
                n.av = 1; n.aop = i0.op;
            end else if (i1.v) begin
                n.av = 1; n.aop = i1.op; n.as = 1;
            end
        end
        cur = n;
    endtask

    task automatic cycle(input ins_t i0, input ins_t i1, input bit st, input bit fl);
        @(negedge clk);
        r0 = i0; r1 = i1; stall = st; flush = fl;
        #1;
        chk("req_ready", req_ready, (held_q.size() == 0) && !st);
        model_step(i0, i1, st, fl);
        exp_q.push_back(cur);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle('0, '0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a_valid"}, av, 0);
        chk({tag, "_a_op"}, aop, 0);
        chk({tag, "_b_valid"}, bv, 0);
        chk({tag, "_split"}, cnt, 0);
        chk({tag, "_split_sat"}, cnt2, 16'hFFFE);
        chk({tag, "_ready"}, req_ready, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        r0 = '0; r1 = '0; stall = 0; flush = 0;
        #2 reset = 1;
        #1 check_zero("async_reset");
        held_q.delete();
        exp_q.delete();
        cur = reset_state();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("a_valid", av, e.av);
                chk("a_op", aop, e.aop);
                chk("a_slot", as, e.as);
                chk("b_valid", bv, e.bv);
                chk("b_op", bop, e.bop);
                chk("b_slot", bs, e.bs);
                chk("split_count", cnt, e.cnt);
                chk("split_count_sat", cnt2, e.cnt2);
            end
        end
    end

    initial begin : stimulus
        ins_t i0, i1;
        cur = reset_state();
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset = 0;
        // independent pair
        cycle(mk(1, 4'b0000, 0, 3, 1, 2), mk(1, 4'b0001, 0, 6, 4, 5), 0, 0);
        idle(1);
        // RAW split
        cycle(mk(1, 4'b0000, 0, 7, 1, 2), mk(1, 4'b0100, 0, 8, 7, 2), 0, 0);
        idle(2);
        // younger branch steers to A
        cycle(mk(1, 4'b0000, 0, 1, 2, 3), mk(1, 4'b1000, 1, 0, 4, 5), 0, 0);
        // two branches split
        cycle(mk(1, 4'b1000, 1, 0, 1, 2), mk(1, 4'b1010, 1, 0, 3, 4), 0, 0);
        idle(2);
        // stall three cycles in HOLD
        cycle(mk(1, 4'b0010, 0, 9, 1, 2), mk(1, 4'b0011, 0, 5, 9, 9), 0, 0);
        repeat (3) cycle('0, '0, 1, 0);
        idle(2);
        // flush in HOLD discards held op
        cycle(mk(1, 4'b0010, 0, 9, 1, 2), mk(1, 4'b0110, 0, 5, 3, 9), 0, 0);
        cycle(mk(1, 4'b0001, 0, 1, 2, 3), '0, 1, 1);
        idle(2);
        // single-valid slot1
        cycle('0, mk(1, 4'b0111, 0, 2, 3, 4), 0, 0);
        idle(1);
        // reset mid-HOLD
        cycle(mk(1, 4'b0000, 0, 7, 1, 2), mk(1, 4'b0100, 0, 8, 7, 2), 0, 0);
        do_reset();
        idle(1);
        // counter ceiling on the preloaded instance
        repeat (2) begin
            cycle(mk(1, 4'b1001, 1, 0, 1, 2), mk(1, 4'b1010, 1, 0, 3, 4), 0, 0);
            idle(1);
        end
        idle(1);
        for (int k = 0; k < 2000; k++) begin
            i0 = mk($urandom_range(0, 3) != 0, 4'($urandom_range(0, 10)), $urandom_range(0, 3) == 0,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            i1 = mk($urandom_range(0, 3) != 0, 4'($urandom_range(0, 10)), $urandom_range(0, 3) == 0,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            cycle(i0, i1, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        end
        idle(2);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
